fifo_pkt_tx: RTL and testbench

FIFO_PKT_TX -- requirements
Module: fifo_pkt_tx

---
 rtl/fifo_pkt_tx.sv | 144 ++++++++++++++
 tb/tb_fifo_pkt_tx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pkt_tx.sv
// Packetiser in front of an async FIFO write port: buffers a payload, then emits
// length header, the payload beats and a zero-sum checksum, one beat per accepted transfer.
module fifo_pkt_tx #(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_LEN    = 16
) (
   input  logic                  wclk,
   input  logic                  wrst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_last,
   output logic                  w_valid,
   input  logic                  w_ready,
   output logic [DATA_WIDTH-1:0] w_data,
   output logic                  trunc_err,
   output logic [15:0]           pkt_count
);

   localparam int LEN_W = $clog2(MAX_LEN + 1);
   localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      SEND_HDR,
      SEND_PAY,
      SEND_CHK
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [LEN_W-1:0]      r_len, w_len_nxt;
   logic [LEN_W-1:0]      r_rd_idx, w_rd_idx_nxt;
   logic [LEN_W-1:0]      w_len_inc, w_rd_inc;
   logic [DATA_WIDTH-1:0] r_sum, w_sum_nxt;
   logic [DATA_WIDTH-1:0] r_w_data, w_w_data_nxt;
   logic                  r_w_valid, w_w_valid_nxt;
   logic                  r_trunc, w_trunc_nxt;
   logic [15:0]           r_pkt_count, w_pkt_count_nxt;
   logic [DATA_WIDTH-1:0] r_buf [MAX_LEN];
   logic                  w_s_fire, w_w_fire, w_final;

   assign s_ready   = (r_state == IDLE) || (r_state == COLLECT);
   assign w_s_fire  = s_valid && s_ready;
   assign w_w_fire  = r_w_valid && w_ready;
   assign w_len_inc = r_len + LEN_W'(1);
   assign w_rd_inc  = r_rd_idx + LEN_W'(1);
   assign w_final   = s_last || (w_len_inc == LEN_W'(MAX_LEN));

   assign w_valid   = r_w_valid;
   assign w_data    = r_w_data;
   assign trunc_err = r_trunc;
   assign pkt_count = r_pkt_count;

   // NOTE: payload storage has no reset; r_len alone decides which entries are valid.
   always_ff @(posedge wclk) begin
      if (w_s_fire)
         r_buf[r_len[IDX_W-1:0]] <= s_data;
   end

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      w_state_nxt     = r_state;
      w_len_nxt       = r_len;
      w_rd_idx_nxt    = r_rd_idx;
      w_sum_nxt       = r_sum;
      w_w_data_nxt    = r_w_data;
      w_w_valid_nxt   = r_w_valid;
      w_trunc_nxt     = r_trunc;
      w_pkt_count_nxt = r_pkt_count;

      unique case (r_state)
         IDLE, COLLECT: begin
            if (w_s_fire) begin
               w_len_nxt = w_len_inc;
               // Each beat adds data+1, so the sum already includes the length header.
               w_sum_nxt = r_sum + s_data + DATA_WIDTH'(1);
               if (w_final) begin
                  w_state_nxt   = SEND_HDR;
                  w_w_valid_nxt = 1'b1;
                  w_w_data_nxt  = DATA_WIDTH'(w_len_inc);
                  if (!s_last)
                     w_trunc_nxt = 1'b1;
               end else begin
                  w_state_nxt = COLLECT;
               end
            end
         end
         SEND_HDR: begin
            if (w_w_fire) begin
               w_state_nxt  = SEND_PAY;
               w_w_data_nxt = r_buf[0];
               w_rd_idx_nxt = LEN_W'(1);
            end
         end
         SEND_PAY: begin
            if (w_w_fire) begin
               if (r_rd_idx == r_len) begin
                  w_state_nxt  = SEND_CHK;
                  w_w_data_nxt = -r_sum;
               end else begin
                  w_w_data_nxt = r_buf[r_rd_idx[IDX_W-1:0]];
                  w_rd_idx_nxt = w_rd_inc;
               end
            end
         end
         SEND_CHK: begin
            if (w_w_fire) begin
               w_state_nxt     = IDLE;
               w_w_valid_nxt   = 1'b0;
               w_len_nxt       = '0;
               w_rd_idx_nxt    = '0;
               w_sum_nxt       = '0;
               w_pkt_count_nxt = r_pkt_count + 16'd1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         r_state     <= IDLE;
         r_len       <= '0;
         r_rd_idx    <= '0;
         r_sum       <= '0;
         r_w_data    <= '0;
         r_w_valid   <= 1'b0;
         r_trunc     <= 1'b0;
         r_pkt_count <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_len       <= w_len_nxt;
         r_rd_idx    <= w_rd_idx_nxt;
         r_sum       <= w_sum_nxt;
         r_w_data    <= w_w_data_nxt;
         r_w_valid   <= w_w_valid_nxt;
         r_trunc     <= w_trunc_nxt;
         r_pkt_count <= w_pkt_count_nxt;
      end
   end

endmodule

// File: tb/tb_fifo_pkt_tx.sv
// Bench for fifo_pkt_tx: a queue model of the emitted beat stream checked every cycle,
// directed packets with literal expectations, then randomized traffic and backpressure.
module tb_fifo_pkt_tx;

   localparam int DW = 8;
   localparam int ML = 16;

   logic          wclk = 1'b0;
   logic          wrst = 1'b0;
   logic          s_valid = 1'b0;
   logic          s_last = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          w_ready = 1'b1;
   logic          s_ready, w_valid, trunc_err;
   logic [DW-1:0] w_data;
   logic [15:0]   pkt_count;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int last_acc_cyc = 0;
   int wr_mode = 0;
   int wr_ph = 0;
   int acc_cyc;

   // Model: bytes still owed on the write port, and the packet being collected.
   logic [7:0]  exp_q[$];
   logic [7:0]  cur[$];
   logic [7:0]  m_sum;
   logic [15:0] m_cnt = '0;
   logic        m_trunc = 1'b0;

   logic [7:0] out_log[$];
   int         log_cyc[$];
   logic [7:0] e[$];

   fifo_pkt_tx #(.DATA_WIDTH(DW), .MAX_LEN(ML)) dut (
      .wclk      (wclk),
      .wrst      (wrst),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .w_valid   (w_valid),
      .w_ready   (w_ready),
      .w_data    (w_data),
      .trunc_err (trunc_err),
      .pkt_count (pkt_count)
   );

   always #5 wclk = ~wclk;

   always @(posedge wclk) cyc = cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge wclk) begin
      #1;
      case (wr_mode)
         0: w_ready = 1'b1;
         1: begin
            w_ready = (wr_ph % 4 == 0) || (wr_ph % 4 == 3);
            wr_ph++;
         end
         default: w_ready = 1'($urandom_range(0, 1));
      endcase
   end

   always @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         exp_q.delete();
         cur.delete();
         m_cnt   = '0;
         m_trunc = 1'b0;
      end else if (exp_q.size() != 0) begin
         if (w_ready) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0)
               m_cnt = m_cnt + 16'd1;
         end
      end else if (s_valid) begin
         cur.push_back(s_data);
         if (s_last || cur.size() == ML) begin
            if (!s_last)
               m_trunc = 1'b1;
            m_sum = 8'(cur.size());
            exp_q.push_back(m_sum);
            foreach (cur[i]) begin
               exp_q.push_back(cur[i]);
               m_sum = m_sum + cur[i];
            end
            exp_q.push_back(8'(0) - m_sum);
            cur.delete();
         end
      end
   end

   always @(negedge wclk) begin
      if (!wrst) begin
         check("s_ready", 32'(s_ready), 32'(exp_q.size() == 0));
         check("w_valid", 32'(w_valid), 32'(exp_q.size() != 0));
         if (exp_q.size() != 0)
            check("w_data", 32'(w_data), 32'(exp_q[0]));
         check("trunc_err", 32'(trunc_err), 32'(m_trunc));
         check("pkt_count", 32'(pkt_count), 32'(m_cnt));
         if (w_valid && w_ready) begin
            out_log.push_back(w_data);
            log_cyc.push_back(cyc);
         end
      end
   end

   task automatic send_beat(input logic [7:0] d, input logic l);
      int  n   = 0;
      logic acc = 1'b0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      while (!acc && n < 2000) begin
         @(negedge wclk);
         acc = s_ready;
         if (acc)
            last_acc_cyc = cyc;
         @(posedge wclk);
         #1;
         n++;
      end
      if (!acc) begin
         errors++;
         checks++;
         $display("FAIL send_timeout: beat %0h never accepted", d);
      end
      s_valid = 1'b0;
      s_data  = 8'($urandom);
      s_last  = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_idle();
      int n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(posedge wclk);
         #1;
         n++;
      end
      if (exp_q.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL idle_timeout: %0d beats still owed", exp_q.size());
      end
      @(posedge wclk);
      #1;
   endtask

   task automatic check_log(input string name);
      check({name, "_len"}, 32'(out_log.size()), 32'(e.size()));
      foreach (e[i])
         if (i < out_log.size())
            check(name, 32'(out_log[i]), 32'(e[i]));
   endtask

   task automatic clear_log();
      out_log.delete();
      log_cyc.delete();
      e.delete();
   endtask

   initial begin
      #1 wrst = 1'b1;
      #1;
      check("rst_w_valid", 32'(w_valid), 32'(0));
      check("rst_s_ready", 32'(s_ready), 32'(1));
      check("rst_w_data", 32'(w_data), 32'(0));
      check("rst_trunc", 32'(trunc_err), 32'(0));
      check("rst_pkt_count", 32'(pkt_count), 32'(0));
      repeat (2) @(posedge wclk);
      #1 wrst = 1'b0;

      // Three-beat packet, no backpressure.
      clear_log();
      send_beat(8'h01, 1'b0);
      send_beat(8'h02, 1'b0);
      send_beat(8'h03, 1'b1);
      acc_cyc = last_acc_cyc;
      wait_idle();
      e.push_back(8'h03); e.push_back(8'h01); e.push_back(8'h02);
      e.push_back(8'h03); e.push_back(8'hF7);
      check_log("pkt3");
      if (log_cyc.size() >= 5) begin
         check("pkt3_hdr_cycle", 32'(log_cyc[0]), 32'(acc_cyc + 1));
         check("pkt3_span", 32'(log_cyc[4] - log_cyc[0]), 32'(4));
      end
      check("pkt3_count", 32'(pkt_count), 32'(1));

      // Single 0xFF beat.
      clear_log();
      send_beat(8'hFF, 1'b1);
      wait_idle();
      e.push_back(8'h01); e.push_back(8'hFF); e.push_back(8'h00);
      check_log("pkt1");
      check("pkt1_trunc", 32'(trunc_err), 32'(0));
      check("pkt1_count", 32'(pkt_count), 32'(2));

      // 17 beats without s_last: truncated at 16, the 17th starts the next packet.
      clear_log();
      for (int i = 0; i < 17; i++)
         send_beat(8'(i), 1'b0);
      send_beat(8'h20, 1'b1);
      wait_idle();
      e.push_back(8'h10);
      for (int i = 0; i < 16; i++)
         e.push_back(8'(i));
      e.push_back(8'h78);
      e.push_back(8'h02); e.push_back(8'h10); e.push_back(8'h20); e.push_back(8'hCE);
      check_log("trunc");
      check("trunc_flag", 32'(trunc_err), 32'(1));
      check("trunc_count", 32'(pkt_count), 32'(4));

      // Four beats under a 1,0,0,1 w_ready pattern.
      clear_log();
      wr_ph   = 0;
      wr_mode = 1;
      send_beat(8'hA0, 1'b0);
      send_beat(8'hB1, 1'b0);
      send_beat(8'hC2, 1'b0);
      send_beat(8'hD3, 1'b1);
      wait_idle();
      wr_mode = 0;
      e.push_back(8'h04); e.push_back(8'hA0); e.push_back(8'hB1);
      e.push_back(8'hC2); e.push_back(8'hD3); e.push_back(8'h16);
      check_log("stall");
      check("stall_count", 32'(pkt_count), 32'(5));

      // Reset in the middle of an 8-beat payload.
      clear_log();
      for (int i = 0; i < 8; i++)
         send_beat(8'(8'h40 + i), 1'(i == 7));
      repeat (3) @(posedge wclk);
      #1 wrst = 1'b1;
      #1;
      check("abort_w_valid", 32'(w_valid), 32'(0));
      check("abort_pkt_count", 32'(pkt_count), 32'(0));
      check("abort_s_ready", 32'(s_ready), 32'(1));
      check("abort_trunc", 32'(trunc_err), 32'(0));
      @(posedge wclk);
      #1 wrst = 1'b0;
      clear_log();
      send_beat(8'h55, 1'b0);
      send_beat(8'hAA, 1'b1);
      wait_idle();
      e.push_back(8'h02); e.push_back(8'h55); e.push_back(8'hAA); e.push_back(8'hFF);
      check_log("after_abort");
      check("after_abort_count", 32'(pkt_count), 32'(1));

      // Random traffic, random backpressure; the per-cycle compare does the checking.
      wr_mode = 2;
      for (int c = 0; c < 3000; c++) begin
         s_valid = ($urandom % 3) != 0;
         s_data  = 8'($urandom);
         s_last  = ($urandom % ((c < 1500) ? 4 : 24)) == 0;
         @(posedge wclk);
         #1;
      end
      s_valid = 1'b0;
      wr_mode = 0;
      wait_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
